// File: rtl/hsid_fifo_reader.sv
// Read-side sequencer for an hsid_fifo: drains len elements per pass for a number of passes,
// recirculating via loop_en on all but the last pass, and streams them out on valid/ready.
module hsid_fifo_reader #(
  parameter int DATA_WIDTH      = 16,
  parameter int FIFO_ADDR_WIDTH = 4,
  parameter int PASS_WIDTH      = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [FIFO_ADDR_WIDTH:0] len,
  input  logic [PASS_WIDTH-1:0]  passes,
  input  logic                   clear_on_done,
  input  logic                   abort,
  input  logic                   fifo_empty,
  input  logic [DATA_WIDTH-1:0]  fifo_data,
  output logic                   fifo_rd_en,
  output logic                   fifo_loop_en,
  output logic                   fifo_clear,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [DATA_WIDTH-1:0]  m_data,
  output logic                   m_last,
  output logic                   m_final,
  output logic                   busy,
  output logic                   done,
  output logic [1:0]             dbg_state
);

  localparam int LW = FIFO_ADDR_WIDTH + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_CLEAR} state_t;

  state_t                  r_state;
  logic [LW-1:0]           r_len;
  logic [PASS_WIDTH-1:0]   r_passes;
  logic                    r_clear_on_done;
  logic                    r_aborted;
  logic [LW-1:0]           r_rd_elem;
  logic [PASS_WIDTH-1:0]   r_rd_pass;
  logic                    r_inflight;
  logic                    r_if_last;
  logic                    r_if_final;
  logic [DATA_WIDTH-1:0]   r_buf_data  [2];
  logic                    r_buf_last  [2];
  logic                    r_buf_final [2];
  logic                    r_wptr;
  logic                    r_rptr;
  logic [1:0]              r_count;
  logic                    r_done;

  logic                    w_pop_out;
  logic [2:0]              w_occ;
  logic                    w_credit;
  logic                    w_issue;
  logic                    w_elem_last;
  logic                    w_pass_last;
  logic                    w_final;

  // Stream handshake: an element transfers on every rising edge where m_valid && m_ready;
  // while m_valid is high and m_ready low, m_data/m_last/m_final are held unchanged.
  assign w_pop_out   = (r_count != 2'd0) && m_ready;
  assign w_occ       = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop_out};
  assign w_credit    = (w_occ < 3'd2);
  assign w_issue     = (r_state == S_RUN) && !abort && !fifo_empty && w_credit;
  assign w_elem_last = (r_rd_elem == r_len - LW'(1));
  assign w_pass_last = (r_rd_pass == r_passes - PASS_WIDTH'(1));
  assign w_final     = w_elem_last && w_pass_last;

  assign fifo_rd_en   = w_issue;
  assign fifo_loop_en = w_issue && !w_pass_last;
  assign fifo_clear   = (r_state == S_CLEAR);
  assign busy         = (r_state != S_IDLE);
  assign done         = r_done;
  assign dbg_state    = r_state;
  assign m_valid      = (r_count != 2'd0);
  assign m_data       = r_buf_data[r_rptr];
  assign m_last       = m_valid && r_buf_last[r_rptr];
  assign m_final      = m_valid && r_buf_final[r_rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_len           <= '0;
      r_passes        <= '0;
      r_clear_on_done <= 1'b0;
      r_aborted       <= 1'b0;
      r_rd_elem       <= '0;
      r_rd_pass       <= '0;
      r_inflight      <= 1'b0;
      r_if_last       <= 1'b0;
      r_if_final      <= 1'b0;
      r_buf_data[0]   <= '0;
      r_buf_data[1]   <= '0;
      r_buf_last[0]   <= 1'b0;
      r_buf_last[1]   <= 1'b0;
      r_buf_final[0]  <= 1'b0;
      r_buf_final[1]  <= 1'b0;
      r_wptr          <= 1'b0;
      r_rptr          <= 1'b0;
      r_count         <= 2'd0;
      r_done          <= 1'b0;
    end else begin
      r_done <= 1'b0;

      // fifo_data is valid the cycle after the pop; tags travel alongside in the in-flight stage.
      if (r_inflight) begin
        r_buf_data[r_wptr]  <= fifo_data;
        r_buf_last[r_wptr]  <= r_if_last;
        r_buf_final[r_wptr] <= r_if_final;
        r_wptr              <= ~r_wptr;
      end
      if (w_pop_out) r_rptr <= ~r_rptr;
      r_count    <= r_count + {1'b0, r_inflight} - {1'b0, w_pop_out};
      r_inflight <= w_issue;
      r_if_last  <= w_elem_last;
      r_if_final <= w_final;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            if ((len != '0) && (passes != '0)) begin
              r_len           <= len;
              r_passes        <= passes;
              r_clear_on_done <= clear_on_done;
              r_aborted       <= 1'b0;
              r_rd_elem       <= '0;
              r_rd_pass       <= '0;
              r_state         <= S_RUN;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (w_issue) begin
            if (w_elem_last) begin
              r_rd_elem <= '0;
              r_rd_pass <= r_rd_pass + PASS_WIDTH'(1);
            end else begin
              r_rd_elem <= r_rd_elem + LW'(1);
            end
            if (w_final) r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if ((r_count == 2'd0) && !r_inflight) begin
            if (r_clear_on_done) begin
              r_state <= S_CLEAR;
            end else begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
            end
          end
        end
        S_CLEAR: begin
          r_state <= S_IDLE;
          r_done  <= !r_aborted;
        end
        default: r_state <= S_IDLE;
      endcase

      // Abort overrides everything above: drop buffered and in-flight data, clear, no done.
      if (abort && (r_state != S_IDLE)) begin
        r_count    <= 2'd0;
        r_wptr     <= 1'b0;
        r_rptr     <= 1'b0;
        r_inflight <= 1'b0;
        r_aborted  <= 1'b1;
        r_done     <= 1'b0;
        r_state    <= S_CLEAR;
      end
    end
  end

endmodule
